alu_cmd_driver: RTL and testbench

- Synthesizable initiator/checker for the ALU: accepts operation commands on a valid/ready port and drives the ALU's A/B/Opin inputs.
- Waits the ALU's latency, then captures result/zero and compares both against an internal reference model.
- Returns a response with mismatch and illegal-opcode flags on a second valid/ready port.
- Replaces hand-written stimulus with an on-chip command stream plus self-check.

---
 rtl/alu_cmd_driver.sv | 161 ++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Command-stream initiator and self-checker for the ALU: drives A/B/Opin, waits the
// ALU latency, compares result/zero against an internal model and returns a response.
module alu_cmd_driver #(
    parameter int W           = 32,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic [3:0]       cmd_op,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [3:0]       alu_op,
    input  logic [W-1:0]     alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic             rsp_zero,
    output logic             rsp_mismatch,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] ops_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int LAT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [LAT_W-1:0]   lat_cnt_r;
    logic [W-1:0]       alu_a_r;
    logic [W-1:0]       alu_b_r;
    logic [3:0]         alu_op_r;
    logic               rsp_valid_r;
    logic [W-1:0]       rsp_result_r;
    logic               rsp_zero_r;
    logic               rsp_mismatch_r;
    logic               rsp_illegal_r;
    logic [CNT_W-1:0]   ops_count_r;
    logic [CNT_W-1:0]   err_count_r;
    logic [W-1:0]       exp_s;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0010, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1010: is_legal = 1'b1;
            default:                   is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [3:0] op);
        case (op)
            4'b0100: ref_model = a & b;
            4'b0101: ref_model = a | b;
            4'b0110: ref_model = a ^ b;
            4'b0111: ref_model = ~(a | b);
            4'b0000: ref_model = a + b;
            4'b0010: ref_model = a - b;
            4'b1010: ref_model = ($signed(a) < $signed(b)) ? {{(W-1){1'b0}}, 1'b1} : {W{1'b0}};
            default: ref_model = {W{1'b0}};
        endcase
    endfunction

    // Expected result for the operation currently presented to the ALU
    always_comb begin
        exp_s = ref_model(alu_a_r, alu_b_r, alu_op_r);
    end

    // Ready is gated by reset itself so it reads 1 in the very first cycle after reset
    assign cmd_ready = (state_r == IDLE) && !reset;

    // Command/execute/response sequencer with statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            lat_cnt_r      <= {LAT_W{1'b0}};
            alu_a_r        <= {W{1'b0}};
            alu_b_r        <= {W{1'b0}};
            alu_op_r       <= 4'b0000;
            rsp_valid_r    <= 1'b0;
            rsp_result_r   <= {W{1'b0}};
            rsp_zero_r     <= 1'b0;
            rsp_mismatch_r <= 1'b0;
            rsp_illegal_r  <= 1'b0;
            ops_count_r    <= {CNT_W{1'b0}};
            err_count_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        if (is_legal(cmd_op)) begin
                            alu_a_r   <= cmd_a;
                            alu_b_r   <= cmd_b;
                            alu_op_r  <= cmd_op;
                            lat_cnt_r <= {LAT_W{1'b0}};
                            state_r   <= EXEC;
                        end else begin
                            // Illegal ops never reach the ALU; answer immediately
                            rsp_result_r   <= {W{1'b0}};
                            rsp_zero_r     <= 1'b0;
                            rsp_mismatch_r <= 1'b0;
                            rsp_illegal_r  <= 1'b1;
                            rsp_valid_r    <= 1'b1;
                            state_r        <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (lat_cnt_r == LAT_W'(ALU_LATENCY)) begin
                        rsp_result_r   <= alu_result;
                        rsp_zero_r     <= alu_zero;
                        rsp_mismatch_r <= (alu_result != exp_s) ||
                                          (alu_zero != (exp_s == {W{1'b0}}));
                        rsp_illegal_r  <= 1'b0;
                        rsp_valid_r    <= 1'b1;
                        state_r        <= RESP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                        if (ops_count_r != {CNT_W{1'b1}}) begin
                            ops_count_r <= ops_count_r + CNT_W'(1);
                        end
                        if ((rsp_mismatch_r || rsp_illegal_r) && (err_count_r != {CNT_W{1'b1}})) begin
                            err_count_r <= err_count_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign alu_op       = alu_op_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_result   = rsp_result_r;
    assign rsp_zero     = rsp_zero_r;
    assign rsp_mismatch = rsp_mismatch_r;
    assign rsp_illegal  = rsp_illegal_r;
    assign ops_count    = ops_count_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Randomized self-checking bench: two drivers (ALU latency 1 and 0) against
// behavioural ALUs, with a scoreboard computing expected responses and counters.
module tb_alu_cmd_driver;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  cmd_a = 32'd0;
    logic [W-1:0]  cmd_b = 32'd0;
    logic [3:0]    cmd_op = 4'd0;
    logic          fault = 1'b0;

    logic          c1_valid = 1'b0, r1_ready = 1'b0, c1_ready;
    logic [W-1:0]  a1_a, a1_b, r1_result, alu1_q;
    logic [3:0]    a1_op;
    logic          r1_valid, r1_zero, r1_mis, r1_ill;
    logic [CW-1:0] ops1, err1;

    logic          c0_valid = 1'b0, r0_ready = 1'b0, c0_ready;
    logic [W-1:0]  a0_a, a0_b, r0_result, alu0_q;
    logic [3:0]    a0_op;
    logic          r0_valid, r0_zero, r0_mis, r0_ill;
    logic [CW-1:0] ops0, err0;

    int n_checks = 0;
    int n_pass   = 0;
    int m_ops = 0, m_err = 0, m0_ops = 0;
    logic [3:0]   m_alu_op = 4'd0;
    logic [W-1:0] obs_result;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [3:0] op);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return ~(a | b);
            4'd0:    return a + b;
            4'd2:    return a - b;
            4'd10:   return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALUs: one registered stage (optionally faulty on add), one combinational
    always @(posedge clk) alu1_q <= ref_model(a1_a, a1_b, a1_op) ^ ((fault && a1_op == 4'd0) ? 32'd1 : 32'd0);
    assign alu0_q = ref_model(a0_a, a0_b, a0_op);

    alu_cmd_driver #(.W(W), .ALU_LATENCY(1), .CNT_W(CW)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(a1_a), .alu_b(a1_b), .alu_op(a1_op),
        .alu_result(alu1_q), .alu_zero(alu1_q == 32'd0),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_result(r1_result),
        .rsp_zero(r1_zero), .rsp_mismatch(r1_mis), .rsp_illegal(r1_ill),
        .ops_count(ops1), .err_count(err1)
    );

    alu_cmd_driver #(.W(W), .ALU_LATENCY(0), .CNT_W(CW)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(c0_valid), .cmd_ready(c0_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(a0_a), .alu_b(a0_b), .alu_op(a0_op),
        .alu_result(alu0_q), .alu_zero(alu0_q == 32'd0),
        .rsp_valid(r0_valid), .rsp_ready(r0_ready), .rsp_result(r0_result),
        .rsp_zero(r0_zero), .rsp_mismatch(r0_mis), .rsp_illegal(r0_ill),
        .ops_count(ops0), .err_count(err0)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit legal_op(input logic [3:0] op);
        return op inside {4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Present a command to dut1 and return at the negedge after its accept edge
    task automatic send1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        int n;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_op = op; c1_valid = 1'b1;
        n = 0;
        while (!c1_ready && n < 20) begin @(negedge clk); n++; end
        check_val("cmd_ready_idle", c1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        c1_valid = 1'b0;
    endtask

    // Wait for, check, optionally hold, then consume dut1's response
    task automatic recv1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                         input bit early, input int hold);
        int n;
        bit legal, mis;
        logic [W-1:0] e;
        legal = legal_op(op);
        e = legal ? ref_model(a, b, op) : 32'd0;
        mis = legal && fault && (op == 4'd0);
        if (mis) e = e ^ 32'd1;
        if (legal) m_alu_op = op;
        r1_ready = early;
        n = 1;
        while (!r1_valid && n < 20) begin @(negedge clk); n++; end
        check_val("latency1", n, legal ? 3 : 1);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            check_val("rsp_valid", r1_valid, 1);
            check_val("rsp_result", r1_result, e);
            check_val("rsp_zero", r1_zero, legal && (e == 32'd0));
            check_val("rsp_mismatch", r1_mis, mis);
            check_val("rsp_illegal", r1_ill, !legal);
            check_val("cmd_ready_busy", c1_ready, 0);
            check_val("alu_op", a1_op, m_alu_op);
        end
        obs_result = r1_result;
        r1_ready = 1'b1;
        @(posedge clk);
        if (m_ops < 65535) m_ops++;
        if ((mis || !legal) && m_err < 65535) m_err++;
        @(negedge clk);
        r1_ready = 1'b0;
        fault = 1'b0;
        check_val("rsp_valid_drop", r1_valid, 0);
        check_val("ops_count", ops1, m_ops);
        check_val("err_count", err1, m_err);
    endtask

    task automatic run0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        int n;
        bit legal;
        legal = legal_op(op);
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_op = op; c0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c0_valid = 1'b0;
        n = 1;
        while (!r0_valid && n < 20) begin @(negedge clk); n++; end
        check_val("latency0", n, legal ? 2 : 1);
        check_val("rsp0_result", r0_result, legal ? ref_model(a, b, op) : 32'd0);
        check_val("rsp0_flags", {r0_mis, r0_ill}, {1'b0, !legal});
        r0_ready = 1'b1;
        @(posedge clk);
        m0_ops++;
        @(negedge clk);
        r0_ready = 1'b0;
    endtask

    logic [W-1:0] dir_a   [9] = '{32'h1B, 32'h1B, 32'h1B, 32'h1B, 32'h1B, 32'h1B, 32'h1B, 32'hFFFF_FFFF, 32'd5};
    logic [W-1:0] dir_b   [9] = '{32'h2E, 32'h2E, 32'h2E, 32'h2E, 32'h2E, 32'h2E, 32'h2E, 32'd1, 32'd5};
    logic [3:0]   dir_op  [9] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd2, 4'd10, 4'd2, 4'd2};
    logic [W-1:0] dir_res [9] = '{32'h0A, 32'h3F, 32'h35, 32'hFFFF_FFC0, 32'h49, 32'hFFFF_FFED, 32'd1, 32'hFFFF_FFFE, 32'd0};

    initial begin
        logic [W-1:0] a, b;
        logic [3:0] op;
        repeat (3) @(negedge clk);
        check_val("reset_cmd_ready", c1_ready, 0);
        check_val("reset_outputs", {r1_valid, a1_a, a1_op, r1_result, ops1, err1}, 0);
        reset = 1'b0;
        #1;
        check_val("post_reset_ready", c1_ready, 1);

        for (int i = 0; i < 9; i++) begin
            send1(dir_a[i], dir_b[i], dir_op[i]);
            recv1(dir_a[i], dir_b[i], dir_op[i], 1'b0, 0);
            check_val("directed_result", obs_result, dir_res[i]);
            if (i == 3) check_val("ops_after_logic", ops1, 4);
        end

        fault = 1'b1;
        send1(32'd1, 32'd2, 4'd0);
        recv1(32'd1, 32'd2, 4'd0, 1'b0, 0);
        check_val("faulty_add_result", obs_result, 32'd2);

        send1(32'h1234, 32'h5678, 4'b1111);
        recv1(32'h1234, 32'h5678, 4'b1111, 1'b0, 0);

        // Held response with a pending command waiting behind it
        send1(32'h1B, 32'h2E, 4'd4);
        cmd_a = 32'hDEAD_BEEF; cmd_b = 32'h0F0F_0F0F; cmd_op = 4'd6; c1_valid = 1'b1;
        recv1(32'h1B, 32'h2E, 4'd4, 1'b0, 5);
        check_val("pending_ready", c1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        c1_valid = 1'b0;
        check_val("pending_accepted", c1_ready, 0);
        check_val("pending_alu_op", a1_op, 4'd6);
        recv1(32'hDEAD_BEEF, 32'h0F0F_0F0F, 4'd6, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            a = pick_operand();
            b = pick_operand();
            op = 4'($urandom_range(0, 15));
            fault = ($urandom_range(0, 7) == 0);
            send1(a, b, op);
            if ($urandom_range(0, 1) == 1) recv1(a, b, op, 1'b1, 0);
            else recv1(a, b, op, 1'b0, $urandom_range(0, 2));
        end

        for (int i = 0; i < 10; i++) begin
            run0(pick_operand(), pick_operand(), (i == 3) ? 4'd9 : 4'($urandom_range(0, 15)));
        end
        check_val("ops0_count", ops0, m0_ops);

        // Reset while dut1 is in EXEC aborts the operation
        send1(32'd7, 32'd9, 4'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("reset_mid_ready", c1_ready, 0);
        reset = 1'b0;
        #1;
        check_val("reset_mid_post_ready", c1_ready, 1);
        check_val("reset_mid_counters", {ops1, err1, a1_op}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("reset_mid_no_rsp", r1_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
